// File: rtl/key_debounce_pulse.sv
// Conditions a raw active-low pushbutton: synchroniser, counter-qualified debounce FSM,
// registered clean level, one-cycle press/release strobes and a wrapping press count.
module key_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned PCNT_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  output logic              key_clean,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [PCNT_W-1:0] press_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   key_s;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                key_clean_q;
  logic                key_clean_d;
  logic                press_pulse_q;
  logic                press_pulse_d;
  logic                release_pulse_q;
  logic                release_pulse_d;
  logic [PCNT_W-1:0]   press_cnt_q;
  logic [PCNT_W-1:0]   press_cnt_d;

  // Shift key_n through the synchroniser; only the last stage is ever observed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  end

  assign key_s = ~sync_q[SYNC_STAGES-1];

  // Synchroniser flops; reset loads the released level so a held key needs a full debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Debounce FSM next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    key_clean_d     = key_clean_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    press_cnt_d     = press_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (key_s) begin
          state_d = PRESS_WAIT;
        end else begin
          state_d = IDLE;
        end
      end

      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = CNT_ZERO;
          key_clean_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_cnt_d   = press_cnt_q + PCNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        cnt_d = CNT_ZERO;
        if (!key_s) begin
          state_d = RELEASE_WAIT;
        end else begin
          state_d = PRESSED;
        end
      end

      RELEASE_WAIT: begin
        // A pressed sample here is a release bounce; the clean level never dropped.
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          cnt_d           = CNT_ZERO;
          key_clean_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = CNT_ZERO;
        key_clean_d = 1'b0;
      end
    endcase
  end

  // FSM state, debounce counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= CNT_ZERO;
      key_clean_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_cnt_q     <= {PCNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_clean_q     <= key_clean_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

  assign key_clean     = key_clean_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: run-length reference model compared every cycle,
// plus directed press/release/bounce/wrap/reset scenarios with literal expectations.
module tb_key_debounce_pulse;

  localparam int D = 8;
  localparam int S = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_n = 1'b1;
  logic         key_clean;
  logic         press_pulse;
  logic         release_pulse;
  logic [W-1:0] press_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [S-1:0] m_hist  = '1;
  int           m_run   = 0;
  logic         m_clean = 1'b0;
  logic         m_pp    = 1'b0;
  logic         m_rp    = 1'b0;
  logic [W-1:0] m_cnt   = '0;
  bit           m_valid = 1'b0;

  int           n_pp = 0;
  int           n_rp = 0;
  bit           wrap_seen = 1'b0;
  logic [W-1:0] prev_cnt = '0;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES(S),
    .PCNT_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .key_clean(key_clean),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the level seen by the debouncer is key_n delayed S samples; a new level is
  // accepted once D+1 consecutive samples disagree with the current clean level.
  initial begin
    logic s;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_hist  = '1;
        m_run   = 0;
        m_clean = 1'b0;
        m_pp    = 1'b0;
        m_rp    = 1'b0;
        m_cnt   = '0;
        m_valid = 1'b1;
      end else begin
        s    = ~m_hist[S-1];
        m_pp = 1'b0;
        m_rp = 1'b0;
        if (s != m_clean) m_run = m_run + 1;
        else              m_run = 0;
        if (m_run == D + 1) begin
          m_clean = s;
          m_run   = 0;
          if (s) begin
            m_pp  = 1'b1;
            m_cnt = m_cnt + 4'd1;
          end else begin
            m_rp = 1'b1;
          end
        end
        m_hist = {m_hist[S-2:0], key_n};
      end
    end
  end

  // Per-cycle compare against the model, plus strobe and wrap bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model", 32'({key_clean, press_pulse, release_pulse, press_cnt}),
                     32'({m_clean, m_pp, m_rp, m_cnt}));
        if (press_pulse === 1'b1) n_pp = n_pp + 1;
        if (release_pulse === 1'b1) n_rp = n_rp + 1;
        if (prev_cnt == 4'd15 && press_cnt == 4'd0) wrap_seen = 1'b1;
        prev_cnt = press_cnt;
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pp0;
    int rp0;

    // 1 reset values
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({key_clean, press_pulse, release_pulse, press_cnt}), 32'd0);
    rst = 1'b0;
    wait_neg(3);

    // 2 clean press: key_clean and press_pulse after edge 10
    key_n = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 chk("press_edge9_clean", 32'(key_clean), 32'd0);
    @(posedge clk);
    #1 chk("press_edge10_clean", 32'(key_clean), 32'd1);
    chk("press_edge10_pulse", 32'(press_pulse), 32'd1);
    chk("press_edge10_cnt", 32'(press_cnt), 32'd1);
    @(posedge clk);
    #1 chk("press_edge11_pulse", 32'(press_pulse), 32'd0);
    chk("press_edge11_cnt", 32'(press_cnt), 32'd1);
    wait_neg(3);

    // 4 clean release
    key_n = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 chk("release_edge9_pulse", 32'(release_pulse), 32'd0);
    chk("release_edge9_clean", 32'(key_clean), 32'd1);
    @(posedge clk);
    #1 chk("release_edge10_pulse", 32'(release_pulse), 32'd1);
    chk("release_edge10_clean", 32'(key_clean), 32'd0);
    @(posedge clk);
    #1 chk("release_edge11_pulse", 32'(release_pulse), 32'd0);
    wait_neg(3);

    // 3 bounce rejection
    key_n = 1'b0; wait_neg(5);
    key_n = 1'b1; wait_neg(1);
    key_n = 1'b0; wait_neg(5);
    key_n = 1'b1; wait_neg(20);
    chk("bounce_clean", 32'(key_clean), 32'd0);
    chk("bounce_cnt", 32'(press_cnt), 32'd1);
    chk("bounce_npress", 32'(n_pp), 32'd1);

    // press then a 3-cycle release glitch
    key_n = 1'b0; wait_neg(14);
    chk("press2_clean", 32'(key_clean), 32'd1);
    chk("press2_cnt", 32'(press_cnt), 32'd2);
    key_n = 1'b1; wait_neg(3);
    key_n = 1'b0; wait_neg(20);
    chk("glitch_clean", 32'(key_clean), 32'd1);
    chk("glitch_nrelease", 32'(n_rp), 32'd1);
    key_n = 1'b1; wait_neg(14);
    chk("release2_clean", 32'(key_clean), 32'd0);
    chk("release2_nrelease", 32'(n_rp), 32'd2);

    // 5 wrap: 16 pairs bring press_cnt from 2 back to 2 through 15->0
    pp0 = n_pp;
    rp0 = n_rp;
    wrap_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      key_n = 1'b0; wait_neg(14);
      key_n = 1'b1; wait_neg(14);
    end
    chk("wrap_cnt", 32'(press_cnt), 32'd2);
    chk("wrap_npress", 32'(n_pp - pp0), 32'd16);
    chk("wrap_nrelease", 32'(n_rp - rp0), 32'd16);
    chk("wrap_seen", 32'(wrap_seen), 32'd1);

    // 6 reset at cnt=4 in PRESS_WAIT with key held
    key_n = 1'b0;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_neg(3);
    chk("midrst_outputs", 32'({key_clean, press_pulse, release_pulse, press_cnt}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 chk("midrst_edge9_clean", 32'(key_clean), 32'd0);
    @(posedge clk);
    #1 chk("midrst_edge10_clean", 32'(key_clean), 32'd1);
    chk("midrst_edge10_pulse", 32'(press_pulse), 32'd1);
    chk("midrst_edge10_cnt", 32'(press_cnt), 32'd1);
    wait_neg(3);
    key_n = 1'b1;
    wait_neg(14);
    chk("final_clean", 32'(key_clean), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
